// File: rtl/r3_triplet_collect.sv
// Radix-3 triplet collector. It gathers samples n-2D, n-D and n of each block into one
// (x0,x1,x2) triplet. All state changes on the falling edge of clk.
module r3_triplet_collect #(
  parameter int D  = 3,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   din,
  output logic          out_valid,
  output logic [31:0]   x0,
  output logic [31:0]   x1,
  output logic [31:0]   x2,
  output logic [KW-1:0] out_k,
  output logic          out_last
);

  typedef enum logic [1:0] {LEG0, LEG1, LEG2} leg_t;

  leg_t          p, p_next;
  logic [KW-1:0] k, k_next;
  logic          k_at_end;
  logic          emit;
  logic [31:0]   dline [2*D];

  // NOTE: every signal driven here gets a default value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    p_next   = p;
    k_next   = k;
    k_at_end = (k == KW'(D - 1));
    emit     = in_valid && (p == LEG2);
    if (in_valid) begin
      if (!k_at_end) begin
        k_next = k + KW'(1);
      end else begin
        k_next = '0;
        case (p)
          LEG0:    p_next = LEG1;
          LEG1:    p_next = LEG2;
          default: p_next = LEG0;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register in this block reads the values from before the edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      p         <= LEG0;
      k         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_k     <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      // NOTE: the delay line is cleared on reset as well, so no stale sample from an abandoned block can reach a triplet.
      for (int i = 0; i < 2*D; i++) dline[i] <= '0;
    end else begin
      p         <= p_next;
      k         <= k_next;
      out_valid <= emit;
      out_last  <= emit && k_at_end;
      if (in_valid) begin
        dline[0] <= din;
        for (int i = 1; i < 2*D; i++) dline[i] <= dline[i-1];
      end
      // dline[D-1] holds sample n-D and dline[2D-1] holds sample n-2D before this shift.
      if (emit) begin
        x0    <= dline[2*D-1];
        x1    <= dline[D-1];
        x2    <= din;
        out_k <= k;
      end
    end
  end

endmodule

// File: tb/tb_r3_triplet_collect.sv
// Self-checking bench for r3_triplet_collect (D=3). A block-level model records samples by
// index n. On every cycle it derives the expected triplet from the block contents.
module tb_r3_triplet_collect;

  localparam int D  = 3;
  localparam int KW = 2;
  localparam int N  = 3 * D;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   din;
  logic          out_valid;
  logic [31:0]   x0, x1, x2;
  logic [KW-1:0] out_k;
  logic          out_last;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] blk [N];
  int          n;
  logic        e_valid, e_last;
  logic [31:0] e_x0, e_x1, e_x2;
  int          e_k;

  r3_triplet_collect #(.D(D), .KW(KW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
    .out_valid(out_valid), .x0(x0), .x1(x1), .x2(x2),
    .out_k(out_k), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    e_valid = 1'b0; e_last = 1'b0;
    e_x0 = '0; e_x1 = '0; e_x2 = '0; e_k = 0;
  endtask

  // Each rising edge checks what the previous falling edge produced, then drives new inputs.
  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    @(posedge clk);
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("out_last",  32'(out_last),  32'(e_last));
    check("out_k",     32'(out_k),     32'(e_k));
    check("x0", x0, e_x0);
    check("x1", x1, e_x1);
    check("x2", x2, e_x2);
    rst = r; in_valid = v; din = d;
    if (r) begin
      model_reset();
    end else begin
      e_valid = 1'b0;
      e_last  = 1'b0;
      if (v) begin
        blk[n] = d;
        if (n >= 2*D) begin
          e_x0 = blk[n-2*D];
          e_x1 = blk[n-D];
          e_x2 = d;
          e_k = n - 2*D;
          e_last = (e_k == D - 1);
          e_valid = 1'b1;
        end
        n = (n + 1) % N;
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);

    // Contiguous block.
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'(i), 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    // Gapped block: a bubble on every other cycle.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 32'(i), 1'b0);
      cyc(1'b0, 32'hBAD0_0000 | 32'(i), 1'b0);
    end
    // Back-to-back blocks.
    for (int i = 0; i < 18; i++) cyc(1'b1, 32'(i), 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    // Mid-block reset, then a new block.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(i), 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    for (int i = 100; i < 109; i++) cyc(1'b1, 32'(i), 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    // Reset together with a valid sample.
    cyc(1'b1, 32'h0000_DEAD, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    // Sign and bit-exactness patterns.
    for (int i = 0; i < 9; i++) begin
      logic [31:0] v;
      v = 32'(i);
      if (i == 0) v = 32'h8000_7FFF;
      if (i == 3) v = 32'hFFFF_0001;
      if (i == 6) v = 32'h0001_FFFF;
      cyc(1'b1, v, 1'b0);
    end
    cyc(1'b0, 32'h0, 1'b0);
    // Random traffic with gaps and occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 99) == 0));
    end
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
